// File: rtl/layer3_collect.sv
// Layer-3 output collector: captures two 32-lane result vectors into a 64-byte frame buffer
// and serves it through a registered read port. Optional sticky error flag: LAYER3_COLLECT_ERR_EN.
module layer3_collect #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LANES      = 32,
   parameter int unsigned ADDR_W     = 6
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic                        wr_en_0_i,
   input  logic                        wr_en_1_i,
   input  logic [LANES*DATA_WIDTH-1:0] din_i,
   input  logic                        rd_en_i,
   input  logic [ADDR_W-1:0]           rd_addr_i,
   input  logic                        release_i,
   output logic [DATA_WIDTH-1:0]       rd_data_o,
   output logic                        rd_valid_o,
   output logic                        full_o,
   output logic                        done_o,
   output logic                        err_o
);

   localparam int unsigned Depth = 2 * LANES;
   localparam int unsigned IdxW  = $clog2(Depth);

   typedef enum logic [1:0] {StIdle, StFill, StReady} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [1:0]            vld_q;
   logic [1:0]            vld_base;
   logic [1:0]            vld_d;
   logic                  accept;
   logic                  we0;
   logic                  we1;
   logic                  addr_oob;
   logic [IdxW-1:0]       rd_idx;

   // A start in any state opens a new frame, so writes that share its cycle belong to it.
   always_comb begin
      accept   = start_i | (state_q == StFill);
      we1      = accept & wr_en_1_i;
      we0      = accept & wr_en_0_i & ~wr_en_1_i;
      vld_base = start_i ? 2'b00 : vld_q;
      vld_d    = vld_base | {we1, we0};
      rd_idx   = rd_addr_i[IdxW-1:0];
      addr_oob = (32'(rd_addr_i) >= Depth);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         vld_q      <= 2'b00;
         rd_data_o  <= '0;
         rd_valid_o <= 1'b0;
         full_o     <= 1'b0;
         done_o     <= 1'b0;
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         done_o <= 1'b0;

         for (int unsigned k = 0; k < LANES; k++) begin
            if (we0) mem_q[k]         <= din_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (we1) mem_q[LANES + k] <= din_i[k*DATA_WIDTH +: DATA_WIDTH];
         end

         // Reads outside READY leave the data register untouched.
         if (rd_en_i && (state_q == StReady)) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= addr_oob ? '0 : mem_q[rd_idx];
         end else begin
            rd_valid_o <= 1'b0;
         end

         if (accept) begin
            vld_q <= vld_d;
            if (vld_d == 2'b11) begin
               state_q <= StReady;
               full_o  <= 1'b1;
            end else begin
               state_q <= StFill;
               full_o  <= 1'b0;
            end
         end else if ((state_q == StReady) && release_i) begin
            state_q <= StIdle;
            vld_q   <= 2'b00;
            full_o  <= 1'b0;
            done_o  <= 1'b1;
         end
      end
   end

`ifdef LAYER3_COLLECT_ERR_EN
   logic err_q;
   logic err_now;

   // Dual strobe or a write into a bank already captured in this frame.
   always_comb begin
      err_now = accept & ((wr_en_0_i & wr_en_1_i) | (we0 & vld_base[0]) | (we1 & vld_base[1]));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (start_i) begin
         err_q <= err_now;
      end else begin
         err_q <= err_q | err_now;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_layer3_collect.sv
// Self-checking bench for layer3_collect: read data is scoreboarded against a byte model
// of the frame buffer; control outputs are checked directly after each cycle.
module tb_layer3_collect;

   localparam int unsigned DW    = 8;
   localparam int unsigned LANES = 32;
   localparam int unsigned AW    = 6;

   logic              clk     = 1'b0;
   logic              rst     = 1'b1;
   logic              start   = 1'b0;
   logic              wr0     = 1'b0;
   logic              wr1     = 1'b0;
   logic [LANES*DW-1:0] din   = '0;
   logic              rd_en   = 1'b0;
   logic [AW-1:0]     rd_addr = '0;
   logic              rel     = 1'b0;
   logic [DW-1:0]     rd_data;
   logic              rd_valid;
   logic              full;
   logic              done;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] exp_mem [64];
   logic [DW-1:0] sb_q [$];
   logic exp_err;

   layer3_collect #(
      .DATA_WIDTH(DW),
      .LANES     (LANES),
      .ADDR_W    (AW)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .wr_en_0_i (wr0),
      .wr_en_1_i (wr1),
      .din_i     (din),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr),
      .release_i (rel),
      .rd_data_o (rd_data),
      .rd_valid_o(rd_valid),
      .full_o    (full),
      .done_o    (done),
      .err_o     (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every valid read byte must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst && rd_valid) begin
         if (sb_q.size() == 0) check_eq("unexpected_rd_valid", 32'd1, 32'd0);
         else check_eq("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
      end
   end

   function automatic logic [LANES*DW-1:0] mk_vec(input logic [7:0] base, input bit ramp);
      logic [LANES*DW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DW +: DW] = base + (ramp ? 8'(k) : 8'd0);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit w0, input bit w1, input bit st, input logic [LANES*DW-1:0] v);
      start = st;
      wr0   = w0;
      wr1   = w1;
      din   = v;
      for (int k = 0; k < LANES; k++) begin
         if (w1) exp_mem[LANES + k] = v[k*DW +: DW];
         else if (w0) exp_mem[k] = v[k*DW +: DW];
      end
      tick();
      start = 1'b0;
      wr0   = 1'b0;
      wr1   = 1'b0;
   endtask

   task automatic rd_burst(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) begin
         rd_en   = 1'b1;
         rd_addr = AW'(a);
         sb_q.push_back(exp_mem[a]);
         tick();
      end
      rd_en = 1'b0;
   endtask

   task automatic release_frame();
      rel = 1'b1;
      tick();
      rel = 1'b0;
   endtask

   initial begin
`ifdef LAYER3_COLLECT_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      for (int i = 0; i < 64; i++) exp_mem[i] = '0;

      // Reset state
      tick();
      tick();
      check_eq("rst_rd_data", 32'(rd_data), 32'h0);
      check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
      check_eq("rst_full", 32'(full), 32'h0);
      check_eq("rst_done", 32'(done), 32'h0);
      check_eq("rst_err", 32'(err), 32'h0);
      rst = 1'b0;
      tick();

      // Read in IDLE is ignored
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check_eq("idle_rd_valid", 32'(rd_valid), 32'h0);

      // Normal frame
      wr(1'b0, 1'b0, 1'b1, '0);
      check_eq("fill_full0", 32'(full), 32'h0);
      wr(1'b1, 1'b0, 1'b0, mk_vec(8'h00, 1'b1));
      check_eq("fill_full1", 32'(full), 32'h0);
      wr(1'b0, 1'b1, 1'b0, mk_vec(8'h80, 1'b1));
      check_eq("frame_full", 32'(full), 32'h1);
      check_eq("frame_err", 32'(err), 32'h0);
      rd_burst(0, 63);
      tick();
      check_eq("rd_valid_drop", 32'(rd_valid), 32'h0);

      // Release with a read in the same cycle
      rd_en   = 1'b1;
      rd_addr = 6'd5;
      sb_q.push_back(exp_mem[5]);
      release_frame();
      rd_en = 1'b0;
      check_eq("rel_done", 32'(done), 32'h1);
      check_eq("rel_full", 32'(full), 32'h0);
      check_eq("rel_rd_valid", 32'(rd_valid), 32'h1);
      rd_en   = 1'b1;
      rd_addr = 6'd9;
      tick();
      rd_en = 1'b0;
      check_eq("done_pulse_end", 32'(done), 32'h0);
      check_eq("post_rel_rd_valid", 32'(rd_valid), 32'h0);
      check_eq("post_rel_rd_hold", 32'(rd_data), 32'h05);

      // Dual strobe: bank 1 captures, bank 0 keeps its earlier vector
      wr(1'b0, 1'b0, 1'b1, '0);
      wr(1'b1, 1'b0, 1'b0, mk_vec(8'h40, 1'b1));
      check_eq("dual_pre_err", 32'(err), 32'h0);
      wr(1'b1, 1'b1, 1'b0, mk_vec(8'h55, 1'b0));
      check_eq("dual_full", 32'(full), 32'h1);
      check_eq("dual_err", 32'(err), 32'(exp_err));
      rd_burst(0, 63);
      release_frame();

      // Overwrite of a captured bank
      wr(1'b0, 1'b0, 1'b1, '0);
      check_eq("start_clr_err", 32'(err), 32'h0);
      wr(1'b1, 1'b0, 1'b0, mk_vec(8'h11, 1'b0));
      wr(1'b1, 1'b0, 1'b0, mk_vec(8'h22, 1'b0));
      check_eq("ovw_full", 32'(full), 32'h0);
      check_eq("ovw_err", 32'(err), 32'(exp_err));
      wr(1'b0, 1'b1, 1'b0, mk_vec(8'h33, 1'b0));
      check_eq("ovw_frame_full", 32'(full), 32'h1);
      rd_burst(0, 0);
      rd_burst(63, 63);
      tick();
      release_frame();

      // Asynchronous reset mid-frame
      wr(1'b0, 1'b0, 1'b1, '0);
      wr(1'b1, 1'b0, 1'b0, mk_vec(8'h66, 1'b1));
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_rd_data", 32'(rd_data), 32'h0);
      check_eq("arst_rd_valid", 32'(rd_valid), 32'h0);
      check_eq("arst_full", 32'(full), 32'h0);
      check_eq("arst_done", 32'(done), 32'h0);
      check_eq("arst_err", 32'(err), 32'h0);
      for (int i = 0; i < 64; i++) exp_mem[i] = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      wr(1'b1, 1'b0, 1'b1, mk_vec(8'h01, 1'b1));
      wr(1'b0, 1'b1, 1'b0, mk_vec(8'hA0, 1'b1));
      check_eq("clean_full", 32'(full), 32'h1);
      check_eq("clean_err", 32'(err), 32'h0);
      rd_burst(0, 1);
      rd_burst(33, 33);
      tick();

      // Restart from READY with a bank 1 write riding on start
      wr(1'b0, 1'b1, 1'b1, mk_vec(8'hC0, 1'b1));
      check_eq("restart_full", 32'(full), 32'h0);
      wr(1'b1, 1'b0, 1'b0, mk_vec(8'hE0, 1'b1));
      check_eq("restart_frame_full", 32'(full), 32'h1);
      check_eq("restart_err", 32'(err), 32'h0);
      rd_burst(0, 0);
      rd_burst(32, 33);
      tick();
      tick();
      check_eq("sb_drain", 32'(sb_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
